// File: rtl/jump_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// jump_redirect_ctrl_pkg
// Shared definitions for the jump redirect controller:
//   - opcode constants for the four control-transfer instructions
//   - 2-bit FSM state encoding (IDLE, WAIT_RS, REDIRECT)
//   - 16-bit modulo adder helper used for jump target computation
// ---------------------------------------------------------------------------
package jump_redirect_ctrl_pkg;

    localparam logic [4:0] OP_J    = 5'b00100;  // PC-relative, no link
    localparam logic [4:0] OP_JR   = 5'b00101;  // Rs-relative, no link
    localparam logic [4:0] OP_JAL  = 5'b00110;  // PC-relative, link to R7
    localparam logic [4:0] OP_JALR = 5'b00111;  // Rs-relative, link to R7

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RS  = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    // Target arithmetic wraps modulo 2^16; the carry is dropped on purpose.
    function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/jump_redirect_ctrl_if.sv
// ---------------------------------------------------------------------------
// jump_redirect_ctrl_if
// Bundles every non-clock signal of the jump redirect controller.
//   Decode side  : id_valid, id_opcode, id_pc_plus2, id_imm -> ; <- id_stall, flush_if
//   Hazard unit  : rs_data, rs_ready ->
//   Fetch side   : fetch_ready, ext_flush -> ; <- redir_valid, redir_pc
//   R7 write port: <- r7_we, r7_wdata
//   Debug        : <- dbg_state (current FSM state)
// Modports:
//   slave  - the controller itself (consumes decode/hazard/fetch inputs)
//   master - the surrounding pipeline / testbench that drives those inputs
//
// Redirect handshake: redir_valid is raised from registered state and holds
// redir_pc stable until a cycle where redir_valid && fetch_ready && !ext_flush;
// that cycle is the transfer. A cycle with ext_flush voids any transfer.
// ---------------------------------------------------------------------------
interface jump_redirect_ctrl_if
    import jump_redirect_ctrl_pkg::*;
();
    logic        id_valid;
    logic [4:0]  id_opcode;
    logic [15:0] id_pc_plus2;
    logic [15:0] id_imm;
    logic [15:0] rs_data;
    logic        rs_ready;
    logic        fetch_ready;
    logic        ext_flush;
    logic        id_stall;
    logic        flush_if;
    logic        redir_valid;
    logic [15:0] redir_pc;
    logic        r7_we;
    logic [15:0] r7_wdata;
    state_e      dbg_state;

    modport slave (
        input  id_valid, id_opcode, id_pc_plus2, id_imm, rs_data, rs_ready,
               fetch_ready, ext_flush,
        output id_stall, flush_if, redir_valid, redir_pc, r7_we, r7_wdata,
               dbg_state
    );

    modport master (
        output id_valid, id_opcode, id_pc_plus2, id_imm, rs_data, rs_ready,
               fetch_ready, ext_flush,
        input  id_stall, flush_if, redir_valid, redir_pc, r7_we, r7_wdata,
               dbg_state
    );

endinterface

// File: rtl/jump_redirect_ctrl_jump_class.sv
// ---------------------------------------------------------------------------
// jump_class
// Combinational opcode classifier for control-transfer instructions.
//   opcode_i  in  5  decode opcode
//   is_jump_o out 1  opcode is J, JR, JAL or JALR
//   uses_rs_o out 1  target is Rs-relative (JR, JALR)
//   links_o   out 1  instruction writes the link value to R7 (JAL, JALR)
// ---------------------------------------------------------------------------
module jump_class
    import jump_redirect_ctrl_pkg::*;
(
    input  logic [4:0] opcode_i,
    output logic       is_jump_o,
    output logic       uses_rs_o,
    output logic       links_o
);

    always_comb begin
        is_jump_o = 1'b0;
        uses_rs_o = 1'b0;
        links_o   = 1'b0;
        case (opcode_i)
            OP_J: begin
                is_jump_o = 1'b1;
            end
            OP_JR: begin
                is_jump_o = 1'b1;
                uses_rs_o = 1'b1;
            end
            OP_JAL: begin
                is_jump_o = 1'b1;
                links_o   = 1'b1;
            end
            OP_JALR: begin
                is_jump_o = 1'b1;
                uses_rs_o = 1'b1;
                links_o   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/jump_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// jump_redirect_ctrl
// Decode-stage sequencer for J/JR/JAL/JALR. Captures a jump, stalls decode
// while an Rs-relative target operand is outstanding, kills the wrong-path
// fetch, issues a PC redirect with valid/ready and, on the accepted redirect,
// pulses the R7 link write.
// Ports:
//   clk    in  clock, rising-edge state updates
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of jump_redirect_ctrl_if (all data/handshake signals)
// ---------------------------------------------------------------------------
module jump_redirect_ctrl
    import jump_redirect_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    jump_redirect_ctrl_if.slave   bus
);

    state_e      state_q, state_d;
    logic [15:0] target_q, target_d;
    logic [15:0] link_q, link_d;
    logic [15:0] imm_q, imm_d;
    logic        link_flag_q, link_flag_d;

    logic        is_jump, uses_rs, links;
    logic [15:0] add_base, add_off, add_sum;
    logic        stall, flush, r7_we;

    jump_class u_jump_class (
        .opcode_i  (bus.id_opcode),
        .is_jump_o (is_jump),
        .uses_rs_o (uses_rs),
        .links_o   (links)
    );

    // One shared adder: in WAIT_RS the offset comes from the latched
    // immediate because decode may present anything while stalled.
    always_comb begin
        if (state_q == ST_WAIT_RS) begin
            add_base = bus.rs_data;
            add_off  = imm_q;
        end else begin
            add_base = uses_rs ? bus.rs_data : bus.id_pc_plus2;
            add_off  = bus.id_imm;
        end
        add_sum = add16(add_base, add_off);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            link_q      <= '0;
            imm_q       <= '0;
            link_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            link_q      <= link_d;
            imm_q       <= imm_d;
            link_flag_q <= link_flag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        link_d      = link_q;
        imm_d       = imm_q;
        link_flag_d = link_flag_q;
        stall       = 1'b0;
        flush       = 1'b0;
        r7_we       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.ext_flush && bus.id_valid && is_jump) begin
                    link_d      = bus.id_pc_plus2;
                    link_flag_d = links;
                    if (!uses_rs || bus.rs_ready) begin
                        target_d = add_sum;
                        flush    = 1'b1;
                        state_d  = ST_REDIRECT;
                    end else begin
                        imm_d   = bus.id_imm;
                        stall   = 1'b1;
                        state_d = ST_WAIT_RS;
                    end
                end
            end
            ST_WAIT_RS: begin
                if (bus.ext_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    stall = 1'b1;
                    if (bus.rs_ready) begin
                        target_d = add_sum;
                        flush    = 1'b1;
                        state_d  = ST_REDIRECT;
                    end
                end
            end
            ST_REDIRECT: begin
                // The fetch/decode contents are wrong-path for the whole
                // redirect, so the bubble stays asserted regardless of inputs.
                flush = 1'b1;
                if (bus.ext_flush) begin
                    state_d = ST_IDLE;
                end else if (bus.fetch_ready) begin
                    r7_we   = link_flag_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.id_stall    = stall;
    assign bus.flush_if    = flush;
    assign bus.redir_valid = (state_q == ST_REDIRECT);
    assign bus.redir_pc    = (state_q == ST_REDIRECT) ? target_q : 16'h0000;
    assign bus.r7_we       = r7_we;
    assign bus.r7_wdata    = r7_we ? link_q : 16'h0000;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jump_redirect_ctrl
// Directed bench for jump_redirect_ctrl: behavioural model compared every
// cycle, plus hand-computed redirect targets and link values in queues.
// ---------------------------------------------------------------------------
module tb_jump_redirect_ctrl;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jump_redirect_ctrl_if bus ();

    jump_redirect_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic done      = 1'b0;
    logic final_chk = 1'b0;

    // Hand-computed accepted redirect targets and R7 link values, in order.
    logic [15:0] exp_q[$]    = '{16'h0110, 16'h1FFE, 16'h0002, 16'h4020,
                                 16'h0800, 16'h0043, 16'h1010};
    logic [15:0] r7_exp_q[$] = '{16'h0100, 16'h0500, 16'h0900};

    // model state (committed at posedge) and next values (computed at negedge)
    logic        m_wait, m_req, m_lf;
    logic [15:0] m_tgt, m_lv, m_imm;
    logic        n_wait, n_req, n_lf;
    logic [15:0] n_tgt, n_lv, n_imm;
    logic        e_stall, e_flush, e_valid, e_r7we;
    logic [15:0] e_pc, e_r7d;
    logic        is_j, rsrel, lnk, nj, new_now, new_wait, resume, take;
    logic [15:0] got;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait <= 1'b0; m_req <= 1'b0; m_lf <= 1'b0;
            m_tgt  <= '0;   m_lv  <= '0;   m_imm <= '0;
        end else begin
            m_wait <= n_wait; m_req <= n_req; m_lf <= n_lf;
            m_tgt  <= n_tgt;  m_lv  <= n_lv;  m_imm <= n_imm;
        end
    end

    // compare process
    always @(negedge clk) begin
        if (!rst_n) begin
            e_stall = 0; e_flush = 0; e_valid = 0; e_r7we = 0; e_pc = 0; e_r7d = 0;
            n_wait = 0; n_req = 0; n_lf = 0; n_tgt = 0; n_lv = 0; n_imm = 0;
        end else begin
            is_j  = (bus.id_opcode == 5'b00100) || (bus.id_opcode == 5'b00101) ||
                    (bus.id_opcode == 5'b00110) || (bus.id_opcode == 5'b00111);
            rsrel = (bus.id_opcode == 5'b00101) || (bus.id_opcode == 5'b00111);
            lnk   = (bus.id_opcode == 5'b00110) || (bus.id_opcode == 5'b00111);
            nj       = !m_req && !m_wait && bus.id_valid && is_j && !bus.ext_flush;
            new_now  = nj && (!rsrel || bus.rs_ready);
            new_wait = nj && rsrel && !bus.rs_ready;
            resume   = m_wait && bus.rs_ready && !bus.ext_flush;
            take     = m_req && bus.fetch_ready && !bus.ext_flush;
            e_valid = m_req;
            e_pc    = m_req ? m_tgt : 16'h0000;
            e_r7we  = take && m_lf;
            e_r7d   = e_r7we ? m_lv : 16'h0000;
            e_stall = new_wait || (m_wait && !bus.ext_flush);
            e_flush = m_req || new_now || resume;
            n_wait = m_wait; n_req = m_req; n_lf = m_lf;
            n_tgt = m_tgt;   n_lv = m_lv;   n_imm = m_imm;
            if (bus.ext_flush) begin
                n_wait = 0; n_req = 0;
            end else if (take) begin
                n_req = 0;
            end else if (resume) begin
                n_wait = 0; n_req = 1; n_tgt = bus.rs_data + m_imm;
            end else if (new_now) begin
                n_req = 1;
                n_tgt = rsrel ? bus.rs_data + bus.id_imm : bus.id_pc_plus2 + bus.id_imm;
                n_lv = bus.id_pc_plus2; n_lf = lnk;
            end else if (new_wait) begin
                n_wait = 1; n_imm = bus.id_imm; n_lv = bus.id_pc_plus2; n_lf = lnk;
            end
        end
        chk("id_stall",    32'(bus.id_stall),    32'(e_stall));
        chk("flush_if",    32'(bus.flush_if),    32'(e_flush));
        chk("redir_valid", 32'(bus.redir_valid), 32'(e_valid));
        chk("redir_pc",    32'(bus.redir_pc),    32'(e_pc));
        chk("r7_we",       32'(bus.r7_we),       32'(e_r7we));
        chk("r7_wdata",    32'(bus.r7_wdata),    32'(e_r7d));
        // scoreboard against hand-computed literals
        if (rst_n && bus.redir_valid && bus.fetch_ready && !bus.ext_flush) begin
            if (exp_q.size() == 0) chk("unexpected_redirect", 32'(bus.redir_pc), 32'hFFFF_FFFF);
            else begin
                got = exp_q.pop_front();
                chk("sb_redir_pc", 32'(bus.redir_pc), 32'(got));
            end
        end
        if (rst_n && bus.r7_we) begin
            if (r7_exp_q.size() == 0) chk("unexpected_r7_we", 32'(bus.r7_wdata), 32'hFFFF_FFFF);
            else begin
                got = r7_exp_q.pop_front();
                chk("sb_r7_wdata", 32'(bus.r7_wdata), 32'(got));
            end
        end
        if (done && !final_chk) begin
            final_chk = 1'b1;
            chk("redirects_missing", 32'(exp_q.size()), 32'd0);
            chk("r7_writes_missing", 32'(r7_exp_q.size()), 32'd0);
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic v, input logic [4:0] op, input logic [15:0] pc2,
                          input logic [15:0] imm, input logic rr, input logic [15:0] rd,
                          input logic fr, input logic xf);
        bus.id_valid    = v;
        bus.id_opcode   = op;
        bus.id_pc_plus2 = pc2;
        bus.id_imm      = imm;
        bus.rs_ready    = rr;
        bus.rs_data     = rd;
        bus.fetch_ready = fr;
        bus.ext_flush   = xf;
    endtask

    task automatic idle_in();
        set_in(0, 5'b00000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
    endtask

    initial begin
        idle_in();
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // JAL, immediate redirect accept: target 0x0110, link 0x0100
        set_in(1, 5'b00110, 16'h0100, 16'h0010, 0, 16'h0000, 1, 0);
        tick(1);
        set_in(0, 5'b00000, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0);
        tick(1);
        idle_in(); tick(1);

        // JR waits three cycles for Rs; live imm changes while stalled
        set_in(1, 5'b00101, 16'h0300, 16'hFFFE, 0, 16'h1234, 0, 0);
        tick(1);
        set_in(1, 5'b00101, 16'h0300, 16'h5555, 0, 16'h1234, 0, 0);
        tick(1);
        tick(1);
        set_in(1, 5'b00101, 16'h0300, 16'h5555, 1, 16'h2000, 1, 0);
        tick(1);
        set_in(0, 5'b00000, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0);
        tick(1);
        idle_in(); tick(1);

        // J with target wrap: 0xFFFE + 4 = 0x0002
        set_in(1, 5'b00100, 16'hFFFE, 16'h0004, 0, 16'h0000, 1, 0);
        tick(1);
        idle_in(); bus.fetch_ready = 1; tick(1);
        idle_in(); tick(1);

        // JALR held in REDIRECT for 4 cycles; decode noise ignored
        set_in(1, 5'b00111, 16'h0500, 16'h0020, 1, 16'h4000, 0, 0);
        tick(1);
        for (int i = 0; i < 4; i++) begin
            set_in(1, 5'b00110, 16'h7000 + 16'(i), 16'h0100, 1, 16'h9999, 0, 0);
            tick(1);
        end
        set_in(1, 5'b00110, 16'h7000, 16'h0100, 1, 16'h9999, 1, 0);
        tick(1);
        idle_in(); tick(1);

        // ext_flush during WAIT_RS, even with rs_ready: abort
        set_in(1, 5'b00111, 16'h0600, 16'h0002, 0, 16'h0000, 0, 0);
        tick(1);
        set_in(1, 5'b00111, 16'h0600, 16'h0002, 1, 16'h3000, 1, 1);
        tick(1);
        set_in(0, 5'b00000, 16'h0000, 16'h0000, 1, 16'h3000, 1, 0);
        tick(2);
        idle_in(); tick(1);

        // ext_flush during REDIRECT coinciding with fetch_ready: void
        set_in(1, 5'b00110, 16'h0700, 16'h0100, 0, 16'h0000, 0, 0);
        tick(1);
        set_in(0, 5'b00000, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1);
        tick(1);
        set_in(0, 5'b00000, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0);
        tick(2);

        // ext_flush in IDLE blocks acceptance; non-jump opcodes ignored
        set_in(1, 5'b00100, 16'h0A00, 16'h0010, 1, 16'h0000, 1, 1);
        tick(1);
        set_in(1, 5'b00000, 16'h0A00, 16'h0010, 1, 16'h0000, 1, 0);
        tick(1);
        set_in(1, 5'b01100, 16'h0A00, 16'h0010, 1, 16'h0000, 1, 0);
        tick(1);
        idle_in(); tick(1);

        // back-to-back: JAL (0x0900 + 0xFF00 = 0x0800), then JR 0x0042 + 1
        set_in(1, 5'b00110, 16'h0900, 16'hFF00, 0, 16'h0000, 1, 0);
        tick(1);
        tick(1);
        set_in(1, 5'b00101, 16'h0B00, 16'h0001, 1, 16'h0042, 1, 0);
        tick(1);
        idle_in(); bus.fetch_ready = 1; tick(1);
        idle_in(); tick(1);

        // reset mid-REDIRECT, then a J redirects normally
        set_in(1, 5'b00110, 16'h0800, 16'h0008, 0, 16'h0000, 0, 0);
        tick(1);
        idle_in();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        set_in(1, 5'b00100, 16'h1000, 16'h0010, 0, 16'h0000, 1, 0);
        tick(1);
        idle_in(); bus.fetch_ready = 1; tick(1);
        idle_in(); tick(2);

        done = 1'b1;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jump_redirect_ctrl.md
# jump_redirect_ctrl

Sequencer for control-transfer instructions (J, JR, JAL, JALR) in the decode stage. Captures the jump, stalls decode while a register-indirect target operand is unavailable, kills wrong-path fetch, and issues a PC redirect to fetch with a valid/ready handshake. On the accepted redirect it issues the R7 link write. Sits between decode, the register-file hazard unit, fetch and the R7 write port.

## Interface
- No parameters. Fixed widths: 16-bit PC/data, 5-bit opcode.
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  decode holds a valid instruction
- `id_opcode`  in  5  decode opcode
- `id_pc_plus2`  in  16  PC+2 of the decode instruction
- `id_imm`  in  16  sign-extended immediate (I-form for JR/JALR, displacement for J/JAL)
- `rs_data`  in  16  Rs operand value
- `rs_ready`  in  1  Rs value valid this cycle (no outstanding hazard)
- `fetch_ready`  in  1  fetch accepts the redirect this cycle
- `ext_flush`  in  1  higher-priority redirect (branch/exception) this cycle
- `id_stall`  out  1  hold decode
- `flush_if`  out  1  convert the fetch/decode wrong-path instruction to a bubble
- `redir_valid`  out  1  redirect request
- `redir_pc`  out  16  redirect target
- `r7_we`  out  1  R7 write enable
- `r7_wdata`  out  16  link value

## Operation
- Opcode classes: J 00100 (PC-relative, no link), JR 00101 (Rs-relative, no link), JAL 00110 (PC-relative, link), JALR 00111 (Rs-relative, link). All other opcodes are ignored.
- Target: PC-relative = `id_pc_plus2 + id_imm`; Rs-relative = `rs_data + imm`. Addition is 16-bit modulo 2^16 (wraps, no flag). Link value = `id_pc_plus2`.
- **IDLE**
  - Jump accepted when `id_valid`, the opcode is a jump, and the jump is PC-relative or `rs_ready=1`.
  - On accept: latch target, link value and link flag; `flush_if=1`; go to REDIRECT.
  - Rs-relative jump with `rs_ready=0`: `id_stall=1`; latch opcode, `id_pc_plus2` and `id_imm`; go to WAIT_RS.
- **WAIT_RS**
  - `id_stall=1` every cycle.
  - When `rs_ready=1`: target = `rs_data` + latched imm; `flush_if=1`; go to REDIRECT.
- **REDIRECT**
  - `redir_valid=1`, `redir_pc` = latched target (stable until accepted); `flush_if=1`.
  - `id_valid` is ignored (wrong path).
  - When `fetch_ready=1`: `r7_we` = link flag, `r7_wdata` = link value; go to IDLE.
- **ext_flush** has priority in every state: go to IDLE next cycle; no redirect, no R7 write, `id_stall=0`, no jump acceptance that cycle. If it coincides with a `fetch_ready` handshake, the handshake is void and `r7_we=0`.
- Reset (any state, asynchronous): state IDLE, latched target/link/flag = 0. All outputs 0: `id_stall`, `flush_if`, `redir_valid`, `redir_pc`, `r7_we`, `r7_wdata`.

## Timing
- `redir_valid` and `redir_pc` decode from registered state only.
- `id_stall`, `flush_if` and `r7_we` are combinational from state and inputs in the same cycle.
- Minimum latency: jump accepted in cycle T -> `redir_valid` in T+1 -> with `fetch_ready` in T+1, `r7_we` in T+1 and IDLE in T+2. A new jump can be accepted in T+2.
- WAIT_RS adds one cycle per `rs_ready=0` cycle after T; `rs_ready` rising in cycle W gives `redir_valid` in W+1.
- `fetch_ready` low holds REDIRECT indefinitely with stable outputs.
- Exactly one `r7_we` pulse per completed JAL/JALR; zero for J/JR and for aborted jumps.

## Structure
- Shared package: opcode constants (J, JR, JAL, JALR) and the 2-bit state encoding (IDLE, WAIT_RS, REDIRECT).
- One sub-module: `jump_class`, combinational: opcode -> `is_jump`, `uses_rs`, `links`.
- Target adder and FSM live in the top.

## Test plan
- JAL, `id_pc_plus2=0x0100`, `id_imm=0x0010`, `fetch_ready=1` -> `flush_if` in T; `redir_pc=0x0110` in T+1; `r7_we=1`, `r7_wdata=0x0100` in T+1.
- JR, `rs_ready=0` for 3 cycles, then `rs_data=0x2000`, `id_imm=0xFFFE` -> `id_stall=1` for 3 cycles; then `redir_pc=0x1FFE`; no `r7_we`.
- J with `id_pc_plus2=0xFFFE`, `id_imm=0x0004` -> `redir_pc=0x0002` (wrap).
- JALR in REDIRECT, `fetch_ready=0` for 4 cycles -> `redir_valid` and `redir_pc` stable; single `r7_we` on the accepting cycle.
- `ext_flush` during WAIT_RS, and separately during REDIRECT together with `fetch_ready=1` -> IDLE next cycle; `r7_we=0`; no further `redir_valid`.
- `rst_n` low mid-REDIRECT -> all outputs 0 immediately; IDLE after release; next J redirects normally.
